// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_pkg
//  Description : Shared types and constants for push-button conditioning.
//  Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    // Debounce FSM states; the encoding is fixed at 2 bits.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // 20 ms of stability at a 50 MHz system clock.
    localparam int DEBOUNCE_20MS_50MHZ = 1000000;

endpackage : button_pkg
`default_nettype wire

// File: rtl/button_synchronizer.sv
`default_nettype none
// ============================================================================
//  Module      : button_synchronizer
//  Description : Generic N-flop synchronizer for a single asynchronous input,
//                with asynchronous active-high reset to a chosen level.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_synchronizer #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    // Fewer than two flops gives no metastability protection.
    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("button_synchronizer: SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the raw input through the chain; every stage resets to RESET_VAL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule : button_synchronizer
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Synchronizes one raw push-button pin, corrects its polarity
//                and rejects bounce shorter than DEBOUNCE_CYCLES clocks.
//                Produces a clean level, press/release strobes and a sticky
//                press flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
    parameter int SYNC_STAGES     = 2,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_pin,
    input  logic clear_press,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic press_flag
);

    localparam int              CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    // A one-cycle window would make the counter meaningless.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2");
    end

    logic             w_pressed_raw;
    logic             w_sync_q;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_press_pulse_next;
    logic             w_release_pulse_next;
    logic             w_level_next;
    logic             r_btn_level;
    logic             r_press_pulse;
    logic             r_release_pulse;
    logic             r_press_flag;

    // Everything downstream of this point treats 1 as "pressed".
    assign w_pressed_raw = ACTIVE_LOW ? ~btn_pin : btn_pin;

    // Synchronizer resets to "released" so a held button cannot fake a press.
    button_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (w_pressed_raw),
        .o_sync  (w_sync_q)
    );

    // Next-state, counter and strobe decode; counter stops at DEBOUNCE_CYCLES-1.
    always_comb begin
        w_state_next         = r_state;
        w_cnt_next           = r_cnt;
        w_press_pulse_next   = 1'b0;
        w_release_pulse_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sync_q) begin
                    w_state_next = PRESS_WAIT;
                    w_cnt_next   = c_cnt_one;
                end
            end
            PRESS_WAIT: begin
                if (!w_sync_q) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_next       = PRESSED;
                    w_cnt_next         = '0;
                    w_press_pulse_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
            PRESSED: begin
                if (!w_sync_q) begin
                    w_state_next = RELEASE_WAIT;
                    w_cnt_next   = c_cnt_one;
                end
            end
            RELEASE_WAIT: begin
                if (w_sync_q) begin
                    w_state_next = PRESSED;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_next         = IDLE;
                    w_cnt_next           = '0;
                    w_release_pulse_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // The level follows the accepted state: high in PRESSED and RELEASE_WAIT.
    assign w_level_next = (w_state_next == PRESSED) || (w_state_next == RELEASE_WAIT);

    // State, counter and registered outputs; a new press beats a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_btn_level     <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_press_flag    <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_cnt           <= w_cnt_next;
            r_btn_level     <= w_level_next;
            r_press_pulse   <= w_press_pulse_next;
            r_release_pulse <= w_release_pulse_next;
            r_press_flag    <= w_press_pulse_next ? 1'b1 :
                               (clear_press ? 1'b0 : r_press_flag);
        end
    end

    assign btn_level     = r_btn_level;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign press_flag    = r_press_flag;

endmodule : button_debouncer
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debouncer
//  Description : Directed self-checking bench for button_debouncer with
//                DEBOUNCE_CYCLES=4, SYNC_STAGES=2, ACTIVE_LOW=1 (6-clock
//                pin-to-level latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;
    import button_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic btn_pin;
    logic clear_press;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic press_flag;

    int n_checks = 0;
    int n_fail   = 0;

    button_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_pin       (btn_pin),
        .clear_press   (clear_press),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .press_flag    (press_flag)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs packed as {btn_level, press_pulse, release_pulse, press_flag}.
    task automatic test_reset();
        reset       = 1'b1;
        btn_pin     = 1'b1;
        clear_press = 1'b0;
        step();
        step();
        if ({btn_level, press_pulse, release_pulse, press_flag} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hold outputs got %b want 0000",
                     {btn_level, press_pulse, release_pulse, press_flag});
        end
        n_checks++;
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if ({btn_level, press_pulse, release_pulse, press_flag} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d got %b want 0000", k,
                         {btn_level, press_pulse, release_pulse, press_flag});
            end
            n_checks++;
        end
    endtask

    // Pin goes low; level and pulse appear on the 6th edge, flag with them.
    task automatic test_press();
        logic [3:0] exp;
        btn_pin = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp = (k == 6) ? 4'b1101 : ((k == 7) ? 4'b1001 : 4'b0000);
            if ({btn_level, press_pulse, release_pulse, press_flag} !== exp) begin
                n_fail++;
                $display("FAIL press edge %0d got %b want %b", k,
                         {btn_level, press_pulse, release_pulse, press_flag}, exp);
            end
            n_checks++;
        end
    endtask

    // Pin goes high; release strobe and level fall on the 6th edge, flag sticks.
    task automatic test_release();
        logic [3:0] exp;
        btn_pin = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp = (k < 6) ? 4'b1001 : ((k == 6) ? 4'b0011 : 4'b0001);
            if ({btn_level, press_pulse, release_pulse, press_flag} !== exp) begin
                n_fail++;
                $display("FAIL release edge %0d got %b want %b", k,
                         {btn_level, press_pulse, release_pulse, press_flag}, exp);
            end
            n_checks++;
        end
    endtask

    // 3-clock low glitch is rejected; a later held low restarts the full count.
    task automatic test_bounce();
        logic [3:0] exp;
        btn_pin = 1'b0;
        step();
        step();
        step();
        btn_pin = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if ({btn_level, press_pulse, release_pulse} !== 3'b000) begin
                n_fail++;
                $display("FAIL bounce edge %0d got %b want 000", k,
                         {btn_level, press_pulse, release_pulse});
            end
            n_checks++;
        end
        if (dut.r_state !== IDLE) begin
            n_fail++;
            $display("FAIL bounce_state got %0d want %0d", dut.r_state, IDLE);
        end
        n_checks++;
        btn_pin = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp = (k == 6) ? 4'b1101 : ((k == 7) ? 4'b1001 : 4'b0001);
            if ({btn_level, press_pulse, release_pulse, press_flag} !== exp) begin
                n_fail++;
                $display("FAIL bounce_press edge %0d got %b want %b", k,
                         {btn_level, press_pulse, release_pulse, press_flag}, exp);
            end
            n_checks++;
        end
        btn_pin = 1'b1;
        for (int k = 1; k <= 8; k++) step();
        if ({btn_level, press_flag} !== 2'b01) begin
            n_fail++;
            $display("FAIL bounce_released got %b want 01", {btn_level, press_flag});
        end
        n_checks++;
    endtask

    // Reset two clocks into PRESS_WAIT clears everything at once (flag was 1).
    task automatic test_reset_mid_wait();
        logic [3:0] exp;
        int         n_press;
        btn_pin = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        if (dut.r_state !== PRESS_WAIT) begin
            n_fail++;
            $display("FAIL mid_wait_state got %0d want %0d", dut.r_state, PRESS_WAIT);
        end
        n_checks++;
        #2;
        reset = 1'b1;
        #1;
        if ({btn_level, press_pulse, release_pulse, press_flag} !== 4'b0000 ||
            dut.r_cnt !== '0 || dut.r_state !== IDLE) begin
            n_fail++;
            $display("FAIL async_reset outputs %b cnt %0d state %0d want 0000 0 0",
                     {btn_level, press_pulse, release_pulse, press_flag},
                     dut.r_cnt, dut.r_state);
        end
        n_checks++;
        step();
        step();
        reset   = 1'b0;
        n_press = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (press_pulse === 1'b1) n_press++;
            exp = (k < 6) ? 4'b0000 : ((k == 6) ? 4'b1101 : 4'b1001);
            if ({btn_level, press_pulse, release_pulse, press_flag} !== exp) begin
                n_fail++;
                $display("FAIL post_reset edge %0d got %b want %b", k,
                         {btn_level, press_pulse, release_pulse, press_flag}, exp);
            end
            n_checks++;
        end
        if (n_press != 1) begin
            n_fail++;
            $display("FAIL post_reset_pulse_count got %0d want 1", n_press);
        end
        n_checks++;
    endtask

    // Clear behaviour, including clear coincident with a new press (set wins).
    task automatic test_clear();
        btn_pin = 1'b1;
        for (int k = 1; k <= 8; k++) step();
        if ({btn_level, press_flag} !== 2'b01) begin
            n_fail++;
            $display("FAIL flag_sticky got %b want 01", {btn_level, press_flag});
        end
        n_checks++;
        clear_press = 1'b1;
        step();
        clear_press = 1'b0;
        if (press_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL clear got %b want 0", press_flag);
        end
        n_checks++;
        clear_press = 1'b1;
        step();
        clear_press = 1'b0;
        if (press_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_when_zero got %b want 0", press_flag);
        end
        n_checks++;
        // Clear is high at the same edge that loads press_pulse.
        btn_pin = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        clear_press = 1'b1;
        step();
        if ({btn_level, press_pulse, press_flag} !== 3'b111) begin
            n_fail++;
            $display("FAIL clear_vs_set got %b want 111",
                     {btn_level, press_pulse, press_flag});
        end
        n_checks++;
        step();
        clear_press = 1'b0;
        if ({btn_level, press_pulse, press_flag} !== 3'b100) begin
            n_fail++;
            $display("FAIL clear_after_set got %b want 100",
                     {btn_level, press_pulse, press_flag});
        end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_reset_mid_wait();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_button_debouncer
`default_nettype wire
